// File: rtl/udp_pkg.sv
// Shared UDP definitions: header constants, field widths, arbiter state
// encoding and the per-source configuration payload.
package udp_pkg;

    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned UDP_PROTO   = 17;
    localparam int unsigned PORT_W      = 16;
    localparam int unsigned IP_W        = 32;
    localparam int unsigned BYTE_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [PORT_W-1:0] dest_port;
        logic [PORT_W-1:0] sour_port;
        logic [IP_W-1:0]   dest_ip;
        logic [IP_W-1:0]   sour_ip;
    } udp_cfg_t;

endpackage

// File: rtl/udp_tx_arb_if.sv
// Source-side and packer-side bundle of the UDP transmit arbiter.
// master: arbiter view; slave: sources/packer view.
interface udp_tx_arb_if #(
    parameter int unsigned N_SRC = 4
);
    import udp_pkg::*;

    logic [N_SRC-1:0]        req;
    logic [N_SRC-1:0]        gnt;
    logic [BYTE_W*N_SRC-1:0] src_din;
    logic [N_SRC-1:0]        src_vld;
    logic [N_SRC-1:0]        src_sop;
    logic [N_SRC-1:0]        src_eop;
    logic [PORT_W*N_SRC-1:0] cfg_dest_port;
    logic [PORT_W*N_SRC-1:0] cfg_sour_port;
    logic [IP_W*N_SRC-1:0]   cfg_dest_ip;
    logic [IP_W*N_SRC-1:0]   cfg_sour_ip;
    logic                    pk_done;

    logic [BYTE_W-1:0]       dout;
    logic                    dout_vld;
    logic                    dout_sop;
    logic                    dout_eop;
    logic [PORT_W-1:0]       dest_port;
    logic [PORT_W-1:0]       sour_port;
    logic [IP_W-1:0]         dest_ip;
    logic [IP_W-1:0]         sour_ip;
    logic                    err_drop;
    logic                    busy;

    modport master (
        input  req, src_din, src_vld, src_sop, src_eop,
               cfg_dest_port, cfg_sour_port, cfg_dest_ip, cfg_sour_ip, pk_done,
        output gnt, dout, dout_vld, dout_sop, dout_eop,
               dest_port, sour_port, dest_ip, sour_ip, err_drop, busy
    );

    modport slave (
        output req, src_din, src_vld, src_sop, src_eop,
               cfg_dest_port, cfg_sour_port, cfg_dest_ip, cfg_sour_ip, pk_done,
        input  gnt, dout, dout_vld, dout_sop, dout_eop,
               dest_port, sour_port, dest_ip, sour_ip, err_drop, busy
    );

endinterface

// File: rtl/udp_tx_arb_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr,
// wrapping modulo N. Returns one-hot winner, its index and an any flag.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int unsigned IW = $clog2(N);

    int unsigned pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!any && req[IW'(pos)]) begin
                any                 = 1'b1;
                winner[IW'(pos)]    = 1'b1;
                idx                 = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// Packet-level round-robin arbiter sharing one UDP packer between N_SRC sources.
// Optional grant timeout enabled by defining UDP_ARB_TIMEOUT_EN.
module udp_tx_arb
    import udp_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned GAP   = 2
`ifdef UDP_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic         clk,
    input  logic         rst,
    udp_tx_arb_if.master bus
`ifdef UDP_ARB_TIMEOUT_EN
    , output logic       err_timeout
`endif
);
    localparam int unsigned IW = $clog2(N_SRC);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    arb_state_t        state, state_nxt;
    logic [N_SRC-1:0]  gnt_q, gnt_nxt;
    logic [IW-1:0]     gidx, gidx_nxt;
    logic [IW-1:0]     rr_ptr, rr_nxt;
    udp_cfg_t          cfg_q, cfg_nxt, pick_cfg;
    logic [BYTE_W-1:0] dout_q, dout_nxt;
    logic              vld_q, vld_nxt, sop_q, sop_nxt, eop_q, eop_nxt;
    logic              err_q, err_nxt;
    logic              busy_q;
    logic [15:0]       byte_cnt, byte_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;

    logic [N_SRC-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              g_vld, g_sop, g_eop;
    logic [BYTE_W-1:0] g_din;

`ifdef UDP_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]     tcnt, tcnt_nxt;
    logic              tmo_q, tmo_nxt;
`endif

    rr_pick #(.N(N_SRC)) u_rr_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .winner (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Granted source lanes and the candidate winner's configuration
    assign g_vld = bus.src_vld[gidx];
    assign g_sop = bus.src_sop[gidx];
    assign g_eop = bus.src_eop[gidx];
    assign g_din = bus.src_din[BYTE_W*gidx +: BYTE_W];

    assign pick_cfg.dest_port = bus.cfg_dest_port[PORT_W*pick_idx +: PORT_W];
    assign pick_cfg.sour_port = bus.cfg_sour_port[PORT_W*pick_idx +: PORT_W];
    assign pick_cfg.dest_ip   = bus.cfg_dest_ip[IP_W*pick_idx +: IP_W];
    assign pick_cfg.sour_ip   = bus.cfg_sour_ip[IP_W*pick_idx +: IP_W];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        gidx_nxt  = gidx;
        rr_nxt    = rr_ptr;
        cfg_nxt   = cfg_q;
        dout_nxt  = dout_q;
        vld_nxt   = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        err_nxt   = |(bus.src_vld & ~gnt_q);
        byte_nxt  = byte_cnt;
        gap_nxt   = gap_cnt;
`ifdef UDP_ARB_TIMEOUT_EN
        tcnt_nxt  = tcnt;
        tmo_nxt   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_nxt   = pick_oh;
                    gidx_nxt  = pick_idx;
                    rr_nxt    = IW'((32'(pick_idx) + 32'd1) % N_SRC);
                    cfg_nxt   = pick_cfg;
                    state_nxt = ST_GRANT;
`ifdef UDP_ARB_TIMEOUT_EN
                    tcnt_nxt  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (g_vld && g_sop) begin
                    dout_nxt = g_din;
                    vld_nxt  = 1'b1;
                    sop_nxt  = 1'b1;
                    eop_nxt  = g_eop;
                    byte_nxt = byte_cnt + 16'd1;
                    if (g_eop) begin
                        gnt_nxt   = '0;
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_XFER;
                    end
                end else begin
                    // A byte before sop cannot start a packet
                    if (g_vld) err_nxt = 1'b1;
`ifdef UDP_ARB_TIMEOUT_EN
                    if (tcnt == TW'(TIMEOUT - 1)) begin
                        gnt_nxt   = '0;
                        rr_nxt    = IW'((32'(gidx) + 32'd1) % N_SRC);
                        tmo_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        tcnt_nxt  = tcnt + TW'(1);
                    end
`endif
                end
            end
            ST_XFER: begin
                if (g_vld) begin
                    dout_nxt = g_din;
                    vld_nxt  = 1'b1;
                    sop_nxt  = g_sop;
                    eop_nxt  = g_eop;
                    byte_nxt = byte_cnt + 16'd1;
                    if (g_eop) begin
                        gnt_nxt   = '0;
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.pk_done) begin
                    gap_nxt   = '0;
                    state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) state_nxt = ST_IDLE;
                else                         gap_nxt   = gap_cnt + GW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            cfg_q    <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
`ifdef UDP_ARB_TIMEOUT_EN
            tcnt     <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            gnt_q    <= gnt_nxt;
            gidx     <= gidx_nxt;
            rr_ptr   <= rr_nxt;
            cfg_q    <= cfg_nxt;
            dout_q   <= dout_nxt;
            vld_q    <= vld_nxt;
            sop_q    <= sop_nxt;
            eop_q    <= eop_nxt;
            err_q    <= err_nxt;
            busy_q   <= (state_nxt != ST_IDLE);
            byte_cnt <= byte_nxt;
            gap_cnt  <= gap_nxt;
`ifdef UDP_ARB_TIMEOUT_EN
            tcnt     <= tcnt_nxt;
            tmo_q    <= tmo_nxt;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.dout      = dout_q;
    assign bus.dout_vld  = vld_q;
    assign bus.dout_sop  = sop_q;
    assign bus.dout_eop  = eop_q;
    assign bus.dest_port = cfg_q.dest_port;
    assign bus.sour_port = cfg_q.sour_port;
    assign bus.dest_ip   = cfg_q.dest_ip;
    assign bus.sour_ip   = cfg_q.sour_ip;
    assign bus.err_drop  = err_q;
    assign bus.busy      = busy_q;
`ifdef UDP_ARB_TIMEOUT_EN
    assign err_timeout   = tmo_q;
`endif

endmodule

// File: doc/udp_tx_arb.md
# udp_tx_arb

Packet-level round-robin arbiter that shares one UDP packer datapath between up to N packet sources. Each source requests when it holds a complete payload. The arbiter grants one source at a time and muxes that source's byte stream and port/IP configuration onto the packer input. It holds the configuration stable until the packer reports the packet's end, because the packer builds its header after the payload has been stored. It sits between the per-application payload buffers and the UDP packer.

## Interface
- N_SRC, 4: number of requesters, 2..8
- GAP, 2: idle cycles inserted after packer completion before the next grant, 0..15
- TIMEOUT, 255: cycles a grant may wait for the source's sop (used only with the timeout feature)
- clk in 1: clock
- rst in 1: asynchronous reset, active-high
- req in N_SRC: source i has a complete packet ready; level, held until granted
- gnt out N_SRC: one-hot grant; reset 0
- src_din in 8*N_SRC: payload bytes; source i uses bits [8i+7:8i]
- src_vld / src_sop / src_eop in N_SRC each: per-source stream qualifiers
- cfg_dest_port / cfg_sour_port in 16*N_SRC: per-source UDP ports
- cfg_dest_ip / cfg_sour_ip in 32*N_SRC: per-source IPv4 addresses
- pk_done in 1: single-cycle pulse from the packer's dout_eop
- dout out 8, dout_vld / dout_sop / dout_eop out 1 each: stream to the packer; reset 0
- dest_port / sour_port out 16, dest_ip / sour_ip out 32: selected configuration; reset 0
- err_drop out 1: single-cycle pulse when a byte is discarded; reset 0
- busy out 1: high in every state except IDLE; reset 0

## Operation
- The FSM has five states: IDLE, GRANT, XFER, DRAIN and GAP.
- **IDLE:** if any req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo N_SRC. Register gnt and the winner's four configuration fields. Go to GRANT.
- **GRANT:** wait for src_vld & src_sop from the granted source, then go to XFER. A vld without sop from that source is dropped and pulses err_drop.
- **XFER:** forward the granted source's vld/sop/eop/din. On vld & eop, deassert gnt and go to DRAIN. A single-byte packet (sop and eop together) goes from GRANT directly to DRAIN.
- **DRAIN:** wait for pk_done. Configuration outputs stay frozen. Then go to GAP, or to IDLE when GAP = 0.
- **GAP:** count GAP cycles, then go to IDLE.
- rr_ptr becomes winner+1 modulo N_SRC, updated at the grant. It resets to 0, so source 0 has first priority after reset.
- Bytes with vld from any non-granted source are discarded. Each such cycle produces one err_drop pulse, regardless of how many sources collide.
- The byte counter is 16 bits. It counts forwarded bytes and wraps silently. It is exposed only to the test bench (hierarchical reference).

## Timing
- Grant latency: gnt is asserted on the cycle after req is seen in IDLE. The earliest source sop is the cycle after gnt.
- Datapath latency is 1 cycle: registered mux, src_* at cycle t appears on dout* at t+1.
- Configuration outputs change only at the IDLE-to-GRANT edge and are constant through DRAIN.
- gnt drops on the cycle after the accepted eop. The source must not drive vld after its eop.
- Minimum time between two granted packets: eop, then pk_done, then GAP cycles, then 1 IDLE cycle, then gnt.
- A pk_done pulse outside DRAIN is ignored.
- Reset mid-packet: all outputs go to 0 immediately, the FSM goes to IDLE and rr_ptr goes to 0. A packet partially forwarded to the packer is not terminated. Reset must be applied to the packer as well.

## Configuration
- UDP_ARB_TIMEOUT_EN defined:
  - In GRANT, a counter runs from 0. Reaching TIMEOUT revokes the grant and advances rr_ptr past the offender.
  - The FSM returns to IDLE, and an extra output err_timeout pulses for 1 cycle.
- UDP_ARB_TIMEOUT_EN undefined: GRANT waits indefinitely, and the err_timeout port does not exist.

## Structure
- Shared package udp_pkg holds:
  - The FSM state encoding.
  - Localparams for UDP header length (8), protocol number (17) and field widths (port 16, IP 32, byte 8).
- One sub-module, rr_pick: combinational round-robin first-set-bit selector (req, ptr in; one-hot winner and index out). It is reused by later arbiters.

## Test plan
- **Single source:** req[1] = 1, 4-byte packet 0x11..0x14, cfg_dest_port[1] = 0x1234. Required: gnt = 0010 the cycle after req, dout 0x11..0x14 with 1-cycle lag, sop on byte 0, eop on byte 3, dest_port = 0x1234 until pk_done.
- **Round robin:** req = 1111 held, every packet 2 bytes, pk_done 3 cycles after each eop. Required: grant order 0, 1, 2, 3, 0, with at least GAP = 2 idle cycles before each new gnt.
- **Intruder:** source 2 drives vld for 3 cycles while source 0 is granted. Required: 3 err_drop pulses, and the packer stream carries only source 0 data.
- **Single-byte packet:** sop and eop on the same cycle. Required: dout_sop = dout_eop = 1 on one byte, and the FSM goes GRANT to DRAIN.
- **Reset mid-XFER:** rst after byte 2 of 10. Required: gnt, dout_vld and busy are 0 in the same cycle, and the next request from source 3 is granted ahead of source 0 only if source 0 is not requesting (rr_ptr = 0).
- **With UDP_ARB_TIMEOUT_EN:** a source is granted and never sends sop. Required: err_timeout pulses after 255 cycles, and the next requester is granted.
